// File: rtl/ram_wr_seq_if.sv
// ============================================================================
// Module   : ram_wr_seq_if
// Brief    : Producer handshake and RAM write-port bundle for ram_wr_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_wr_seq_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              clr_addr;
  logic              ram_wr_n;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              busy;
  logic              addr_wrap;

  modport master (
    output in_valid, in_data, clr_addr,
    input  in_ready, ram_wr_n, ram_data, ram_addr, busy, addr_wrap
  );

  modport slave (
    input  in_valid, in_data, clr_addr,
    output in_ready, ram_wr_n, ram_data, ram_addr, busy, addr_wrap
  );
endinterface

`default_nettype wire

// File: rtl/ram_wr_seq.sv
// ============================================================================
// Module   : ram_wr_seq
// Brief    : FIFO-buffered, timed active-low write sequencer filling RAM downward.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_wr_seq #(
  parameter int                ADDR_W     = 11,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = 11'h7FF,
  parameter int                SETUP_CYC  = 1,
  parameter int                PULSE_CYC  = 2,
  parameter int                HOLD_CYC   = 1,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic         clk_50,
  input  logic         reset_n,
  ram_wr_seq_if.slave  bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            state_q;
  logic [CYC_W-1:0]  cyc_q;
  logic              wr_n_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic              clr_pend_q;
  logic              wrap_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full is taken from the registered count only, so a same-cycle pop never admits a push.
  assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      wr_n_q     <= 1'b1;
      data_q     <= '0;
      addr_q     <= START_ADDR;
      addr_cnt_q <= START_ADDR;
      clr_pend_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.clr_addr) addr_cnt_q <= START_ADDR;
          if (!empty) begin
            data_q  <= mem_q[rd_ptr_q];
            addr_q  <= addr_cnt_q;
            cyc_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (bus.clr_addr) clr_pend_q <= 1'b1;
          if (cyc_q == CYC_W'(SETUP_CYC - 1)) begin
            cyc_q   <= '0;
            wr_n_q  <= 1'b0;
            state_q <= S_STROBE;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        S_STROBE: begin
          if (bus.clr_addr) clr_pend_q <= 1'b1;
          if (cyc_q == CYC_W'(PULSE_CYC - 1)) begin
            cyc_q   <= '0;
            wr_n_q  <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        S_HOLD: begin
          if (cyc_q == CYC_W'(HOLD_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= S_IDLE;
            // A reload request wins over both decrement and wrap.
            if (bus.clr_addr || clr_pend_q) begin
              addr_cnt_q <= START_ADDR;
              clr_pend_q <= 1'b0;
            end else if (addr_cnt_q == '0) begin
              addr_cnt_q <= START_ADDR;
              wrap_q     <= 1'b1;
            end else begin
              addr_cnt_q <= addr_cnt_q - ADDR_W'(1);
            end
          end else begin
            if (bus.clr_addr) clr_pend_q <= 1'b1;
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.busy      = (state_q != S_IDLE) || !empty;
  assign bus.ram_wr_n  = wr_n_q;
  assign bus.ram_data  = data_q;
  assign bus.ram_addr  = addr_q;
  assign bus.addr_wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_wr_seq.sv
// ============================================================================
// Module   : tb_ram_wr_seq
// Brief    : Self-checking bench for ram_wr_seq with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_wr_seq;

  localparam int         ADDR_W = 11;
  localparam int         DATA_W = 8;
  localparam int         SETUP  = 1;
  localparam int         PULSE  = 2;
  localparam int         HOLD   = 1;
  localparam int         DEPTH  = 4;
  localparam int         TOTAL  = SETUP + PULSE + HOLD;
  localparam logic [10:0] START = 11'h7FF;

  logic clk_50  = 1'b0;
  logic reset_n = 1'b0;

  ram_wr_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_wr_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(START),
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #10 clk_50 = ~clk_50;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: byte queue plus a countdown of cycles left in the current write.
  logic [7:0]  m_q[$];
  int          m_t    = 0;
  logic [10:0] m_cnt  = START;
  logic [10:0] m_addr = START;
  logic [7:0]  m_data = 8'h00;
  bit          m_pend = 1'b0;
  bit          m_wrap = 1'b0;
  bit          m_push;
  int          cyc = 0;

  always @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_t = 0; m_cnt = START; m_addr = START; m_data = 8'h00;
      m_pend = 1'b0; m_wrap = 1'b0;
    end else begin
      cyc++;
      m_push = bus.in_valid && (m_q.size() < DEPTH);
      m_wrap = 1'b0;
      if (m_t == 0) begin
        if (m_q.size() != 0) begin
          m_data = m_q.pop_front();
          m_addr = m_cnt;
          m_t    = TOTAL;
        end
        if (bus.clr_addr) m_cnt = START;
      end else begin
        if (m_t == 1) begin
          if (bus.clr_addr || m_pend) begin
            m_cnt = START; m_pend = 1'b0;
          end else if (m_cnt == 11'd0) begin
            m_cnt = START; m_wrap = 1'b1;
          end else begin
            m_cnt = m_cnt - 11'd1;
          end
        end else if (bus.clr_addr) begin
          m_pend = 1'b1;
        end
        m_t--;
      end
      if (m_push) m_q.push_back(bus.in_data);
    end
  end

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t  cap[$];
  int   wrap_cnt = 0;
  bit   saw_nr   = 1'b0;
  logic prev_wrn = 1'b1;

  always @(negedge clk_50) begin
    if (reset_n) begin
      chk("in_ready",  32'(bus.in_ready),  32'(m_q.size() < DEPTH));
      chk("busy",      32'(bus.busy),      32'((m_t != 0) || (m_q.size() != 0)));
      chk("ram_wr_n",  32'(bus.ram_wr_n),  32'(!(m_t > HOLD && m_t <= HOLD + PULSE)));
      chk("ram_addr",  32'(bus.ram_addr),  32'(m_addr));
      chk("ram_data",  32'(bus.ram_data),  32'(m_data));
      chk("addr_wrap", 32'(bus.addr_wrap), 32'(m_wrap));
      if (prev_wrn && !bus.ram_wr_n) cap.push_back('{bus.ram_addr, bus.ram_data, cyc});
      if (bus.addr_wrap) wrap_cnt++;
      if (!bus.in_ready) saw_nr = 1'b1;
      prev_wrn = bus.ram_wr_n;
    end else begin
      prev_wrn = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk_50);
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.clr_addr = 1'b0;
    repeat (2) @(negedge clk_50);
    reset_n = 1'b1;
    cap.delete();
    wrap_cnt = 0;
  endtask

  // Holds each byte on in_data until the model says it can be accepted.
  task automatic stream(input int n, input int base);
    int i = 0;
    int guard = 0;
    while (i < n) begin
      @(negedge clk_50);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(base + i);
      if (m_q.size() < DEPTH) i++;
      guard++;
      if (guard > 10 * n + 100) begin
        timeout("stream");
        break;
      end
    end
    @(negedge clk_50);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((m_t != 0 || m_q.size() != 0) && guard < 200) begin
      @(negedge clk_50);
      guard++;
    end
    if (guard >= 200) timeout("wait_idle");
  endtask

  task automatic wait_phase(input int t);
    int guard = 0;
    do begin
      @(negedge clk_50);
      guard++;
    end while (m_t != t && guard < 200);
    if (guard >= 200) timeout("wait_phase");
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          clr;
    logic [10:0] exp_addr;
  } vec_t;

  vec_t     tbl [5];
  bit [5:1] wrn_pat = 5'b11001;
  int       bad;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 11'h7FF};
    tbl[1] = '{8'h3C, 1'b0, 11'h7FE};
    tbl[2] = '{8'h5A, 1'b1, 11'h7FF};
    tbl[3] = '{8'hFF, 1'b0, 11'h7FE};
    tbl[4] = '{8'h00, 1'b0, 11'h7FD};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.clr_addr = 1'b0;

    // Reset state, then reset while the strobe is low.
    repeat (3) @(negedge clk_50);
    chk("rst_wr_n", 32'(bus.ram_wr_n), 32'd1);
    chk("rst_addr", 32'(bus.ram_addr), 32'h7FF);
    chk("rst_data", 32'(bus.ram_data), 32'h00);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    stream(1, 8'hC3);
    wait_phase(3);
    chk("strobe_low_pre_rst", 32'(bus.ram_wr_n), 32'd0);
    #3 reset_n = 1'b0;
    #1 chk("rst_async_wr_n", 32'(bus.ram_wr_n), 32'd1);
    repeat (2) @(negedge clk_50);
    reset_n = 1'b1;
    @(negedge clk_50);
    chk("post_rst_addr", 32'(bus.ram_addr), 32'h7FF);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    cap.delete();

    // Single-byte vectors with exact strobe timing.
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      if (tbl[v].clr) begin
        @(negedge clk_50); bus.clr_addr = 1'b1;
        @(negedge clk_50); bus.clr_addr = 1'b0;
      end
      stream(1, int'(tbl[v].data));
      chk("tbl_busy_e0", 32'(bus.busy), 32'd1);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk_50);
        chk("tbl_wr_n", 32'(bus.ram_wr_n), 32'(wrn_pat[k]));
        chk("tbl_busy", 32'(bus.busy), 32'(k < 5));
        if (k == 1 || k == 5) begin
          chk("tbl_addr", 32'(bus.ram_addr), 32'(tbl[v].exp_addr));
          chk("tbl_data", 32'(bus.ram_data), 32'(tbl[v].data));
        end
      end
    end

    // Burst of six with back-pressure.
    do_reset();
    saw_nr = 1'b0;
    stream(6, 1);
    wait_idle();
    chk("burst_ready_low_seen", 32'(saw_nr), 32'd1);
    chk("burst_count", 32'(cap.size()), 32'd6);
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      chk("burst_addr", 32'(cap[i].addr), 32'(11'h7FF - 11'(i)));
      chk("burst_data", 32'(cap[i].data), 32'(i + 1));
      if (i > 0) chk("burst_period", 32'(cap[i].cyc - cap[i-1].cyc), 32'd5);
    end

    // Clear during the strobe of the write to 0x7F0.
    do_reset();
    stream(15, 8'h10);
    wait_idle();
    stream(1, 8'h55);
    wait_phase(3);
    bus.clr_addr = 1'b1;
    @(negedge clk_50);
    bus.clr_addr = 1'b0;
    wait_idle();
    chk("clr_strobe_count", 32'(cap.size()), 32'd16);
    if (cap.size() > 0) chk("clr_strobe_addr", 32'(cap[cap.size()-1].addr), 32'h7F0);
    stream(1, 8'h66);
    wait_idle();
    if (cap.size() > 0) chk("clr_strobe_next", 32'(cap[cap.size()-1].addr), 32'h7FF);

    // Full sweep of the address space and the wrap.
    do_reset();
    stream(2049, 0);
    wait_idle();
    chk("wrap_count_writes", 32'(cap.size()), 32'd2049);
    bad = 0;
    for (int i = 0; i < 2048 && i < cap.size(); i++) begin
      if (cap[i].addr !== 11'(2047 - i) || cap[i].data !== 8'(i)) bad++;
    end
    chk("wrap_sweep_errors", 32'(bad), 32'd0);
    if (cap.size() > 2048) chk("wrap_next_addr", 32'(cap[2048].addr), 32'h7FF);
    chk("wrap_pulses", 32'(wrap_cnt), 32'd1);

    // Clear on the HOLD->IDLE edge of the write to 0x000.
    do_reset();
    stream(2047, 0);
    wait_idle();
    stream(1, 8'hEE);
    wait_phase(1);
    bus.clr_addr = 1'b1;
    @(negedge clk_50);
    bus.clr_addr = 1'b0;
    wait_idle();
    if (cap.size() > 0) chk("clr_exit_addr", 32'(cap[cap.size()-1].addr), 32'h000);
    stream(1, 8'h77);
    wait_idle();
    if (cap.size() > 0) chk("clr_exit_next", 32'(cap[cap.size()-1].addr), 32'h7FF);
    chk("clr_exit_no_wrap", 32'(wrap_cnt), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_50);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      bus.clr_addr = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk_50);
    bus.in_valid = 1'b0;
    bus.clr_addr = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_wr_seq.md
# ram_wr_seq

Write sequencer for the temperature-averaging system's external RAM port. It accepts averaged data bytes from the averaging datapath through a valid/ready interface and buffers them in a small FIFO. It issues one timed, active-low write strobe per byte to the 2K x 8 RAM, starting at the top address and filling downward. It owns `ram_wr_n`, `ram_data` and `ram_addr`, and runs entirely in the 50 MHz domain.

## Interface

Parameters:
- `ADDR_W`, 11: RAM address width.
- `DATA_W`, 8: RAM data width.
- `START_ADDR`, 11'h7FF: first write address and reload value.
- `SETUP_CYC`, 1: cycles that address/data are stable before the strobe falls (>=1).
- `PULSE_CYC`, 2: cycles `ram_wr_n` is held low (>=1).
- `HOLD_CYC`, 1: cycles that address/data are held after the strobe rises (>=1).
- `FIFO_DEPTH`, 4: input buffer entries (power of 2, >=2).

Ports:
- `clk_50` input 1: single clock; all state is updated on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input DATA_W: averaged byte to be written.
- `in_ready` output 1: FIFO can accept; `in_ready = !full`, from registered count only.
- `clr_addr` input 1: synchronous request to reload the address counter to START_ADDR.
- `ram_wr_n` output 1: RAM write strobe, active low, registered.
- `ram_data` output DATA_W: RAM write data, registered.
- `ram_addr` output ADDR_W: RAM write address, registered.
- `busy` output 1: FSM is not in IDLE or the FIFO is non-empty.
- `addr_wrap` output 1: one-cycle pulse when the address wraps from 0 to START_ADDR.

## Operation

- Reset values (asynchronous, immediate): `ram_wr_n`=1, `ram_data`=0, `ram_addr`=START_ADDR, FIFO empty, `in_ready`=1, `busy`=0, `addr_wrap`=0, FSM=IDLE, pending-clear flag=0. Reset mid-strobe raises `ram_wr_n` at once. The in-flight byte and all buffered bytes are discarded.
- Push: a byte is accepted on a rising edge with `in_valid && in_ready`. When full, `in_valid` is ignored, even in a cycle where the FIFO pops.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into `ram_data`, drive `ram_addr` from the address counter, and go to SETUP. Otherwise stay, holding the last `ram_data`/`ram_addr`.
  - SETUP: stay SETUP_CYC cycles, then go to STROBE with `ram_wr_n` registered to 0.
  - STROBE: `ram_wr_n`=0 for PULSE_CYC cycles, then go to HOLD with `ram_wr_n` registered to 1.
  - HOLD: stay HOLD_CYC cycles with address/data unchanged, then go to IDLE and update the address counter.
- Address update at HOLD->IDLE:
  - If the pending clear is set, reload to START_ADDR and clear the flag.
  - Else if the counter is 0, load START_ADDR and pulse `addr_wrap` for one cycle.
  - Else decrement by 1.
- `clr_addr` handling:
  - In IDLE, the counter reloads at the next edge.
  - In SETUP/STROBE/HOLD, the request sets the pending flag, so the address of the write in progress never changes.
  - `clr_addr` on the HOLD->IDLE edge itself reloads; reload beats both decrement and wrap, and no `addr_wrap` pulse is produced.
- `ram_data`/`ram_addr` change only on the IDLE->SETUP edge, or on reset.
- The address counter is internal and is copied to `ram_addr` only at IDLE->SETUP.

## Timing

- Byte accepted on edge E0 (FIFO previously empty, FSM in IDLE):
  - E1: IDLE->SETUP; `ram_addr`/`ram_data` valid.
  - E1+SETUP_CYC: `ram_wr_n` falls.
  - +PULSE_CYC: `ram_wr_n` rises.
  - +HOLD_CYC: back to IDLE.
- With defaults, `ram_wr_n` is low from E2 to E4 and the FSM is in IDLE at E5.
- Write period with the FIFO continuously non-empty: 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles (5 with defaults).
- `in_ready` reflects the count after the edge. A pop frees a slot that is visible to the producer from the next cycle.
- `busy` is combinational from the FSM state and the FIFO count.

## Test plan

- Reset mid-STROBE: assert `reset_n`=0 while `ram_wr_n`=0 -> `ram_wr_n`=1 immediately; after release, `ram_addr`=0x7FF, `in_ready`=1, `busy`=0.
- Single byte 0xA5 accepted at E0 -> `ram_addr`=0x7FF and `ram_data`=0xA5 from E1; `ram_wr_n` low exactly during E2–E4; idle at E5; the next write uses address 0x7FE.
- Burst of 6 bytes 0x01..0x06 with `in_valid` held high:
  - `in_ready` deasserts after 4 pending entries, with no byte lost or duplicated.
  - Six strobes occur 5 cycles apart at addresses 0x7FF..0x7FA, with data 0x01..0x06 in order.
- 2048 consecutive writes -> addresses 0x7FF down to 0x000. `addr_wrap` pulses once, after the write to 0x000, and the next write goes to 0x7FF.
- `clr_addr` pulsed during STROBE of a write to 0x7F0 -> that write completes at 0x7F0, and the next write goes to 0x7FF.
- `clr_addr` on the HOLD->IDLE edge of a write to 0x000 -> the next write goes to 0x7FF and `addr_wrap` stays 0.
